// File: rtl/spi_slave.sv
// spi_slave: SPI target supporting all four CPOL/CPHA modes.
// The SPI pins are oversampled in the clk domain; nothing is clocked by sclk.
// Words are DATA_WIDTH bits, MSB first, back-to-back within one csb-low frame.
//
// Ports:
//   clk, resetb          system clock, asynchronous active-low reset
//   CPOL, CPHA           SPI mode (static while busy)
//   sclk, csb, din       asynchronous SPI inputs from the master
//   dout                 serial data to the master
//   tx_data, tx_load     parallel word into the one-entry tx buffer
//   tx_ready             tx buffer empty
//   rx_data, rx_valid    last complete received word, one-cycle update strobe
//   busy                 synchronized csb is low
//   tx_underrun          word started with the tx buffer empty
//   frame_abort          csb rose with a partial word in flight
module spi_slave #(
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  resetb,
    input  logic                  CPOL,
    input  logic                  CPHA,
    input  logic                  sclk,
    input  logic                  csb,
    input  logic                  din,
    output logic                  dout,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_load,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  busy,
    output logic                  tx_underrun,
    output logic                  frame_abort
);

    localparam int unsigned CntW = $clog2(DATA_WIDTH + 1);

    typedef enum logic [0:0] {StIdle, StActive} state_e;

    state_e                state_q, state_d;
    logic [2:0]            sclk_sync_q, sclk_sync_d;
    logic [1:0]            csb_sync_q, csb_sync_d;
    logic [1:0]            din_sync_q, din_sync_d;
    logic [CntW-1:0]       bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] tx_sr_q, tx_sr_d;
    logic [DATA_WIDTH-1:0] rx_sr_q, rx_sr_d;
    logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
    logic [DATA_WIDTH-1:0] tx_buf_q, tx_buf_d;
    logic                  tx_full_q, tx_full_d;
    logic                  dout_q, dout_d;
    logic                  rx_valid_q, rx_valid_d;
    logic                  tx_underrun_q, tx_underrun_d;
    logic                  frame_abort_q, frame_abort_d;

    logic sclk_s, sclk_prev, csb_s, din_s;
    logic sclk_rise, sclk_fall, lead_edge, trail_edge, sample_edge, shift_edge;
    logic word_load;

    assign sclk_s    = sclk_sync_q[1];
    assign sclk_prev = sclk_sync_q[2];
    assign csb_s     = csb_sync_q[1];
    assign din_s     = din_sync_q[1];

    assign sclk_rise   = sclk_s & ~sclk_prev;
    assign sclk_fall   = ~sclk_s & sclk_prev;
    assign lead_edge   = CPOL ? sclk_fall : sclk_rise;
    assign trail_edge  = CPOL ? sclk_rise : sclk_fall;
    assign sample_edge = CPHA ? trail_edge : lead_edge;
    assign shift_edge  = CPHA ? lead_edge : trail_edge;

    always_comb begin
        sclk_sync_d   = {sclk_sync_q[1:0], sclk};
        csb_sync_d    = {csb_sync_q[0], csb};
        din_sync_d    = {din_sync_q[0], din};
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        tx_sr_d       = tx_sr_q;
        rx_sr_d       = rx_sr_q;
        rx_data_d     = rx_data_q;
        tx_buf_d      = tx_buf_q;
        tx_full_d     = tx_full_q;
        rx_valid_d    = 1'b0;
        tx_underrun_d = 1'b0;
        frame_abort_d = 1'b0;
        word_load     = 1'b0;

        unique case (state_q)
            StIdle: begin
                bit_cnt_d = '0;
                if (!csb_s) begin
                    state_d   = StActive;
                    word_load = 1'b1;
                end
            end
            StActive: begin
                if (csb_s) begin
                    // Partial word is dropped; the tx buffer is left alone.
                    state_d       = StIdle;
                    bit_cnt_d     = '0;
                    frame_abort_d = (bit_cnt_q != '0);
                end else if (sample_edge) begin
                    rx_sr_d = {rx_sr_q[DATA_WIDTH-2:0], din_s};
                    if (bit_cnt_q == CntW'(DATA_WIDTH - 1)) begin
                        rx_data_d  = rx_sr_d;
                        rx_valid_d = 1'b1;
                        bit_cnt_d  = '0;
                        word_load  = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CntW'(1);
                    end
                end else if (shift_edge && (bit_cnt_q != '0)) begin
                    // With bit_cnt at 0 the new word's MSB must stay on dout.
                    tx_sr_d = {tx_sr_q[DATA_WIDTH-2:0], 1'b0};
                end
            end
            default: state_d = StIdle;
        endcase

        if (word_load) begin
            if (tx_full_q) begin
                tx_sr_d   = tx_buf_q;
                tx_full_d = 1'b0;
            end else if (tx_load) begin
                // Bypass: the word goes straight to the shifter, buffer stays empty.
                tx_sr_d = tx_data;
            end else begin
                tx_sr_d       = '0;
                tx_underrun_d = 1'b1;
            end
        end else if (tx_load && !tx_full_q) begin
            tx_buf_d  = tx_data;
            tx_full_d = 1'b1;
        end

        dout_d = (state_d == StActive) ? tx_sr_d[DATA_WIDTH-1] : 1'b0;
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state_q       <= StIdle;
            sclk_sync_q   <= 3'b000;
            csb_sync_q    <= 2'b11;
            din_sync_q    <= 2'b00;
            bit_cnt_q     <= '0;
            tx_sr_q       <= '0;
            rx_sr_q       <= '0;
            rx_data_q     <= '0;
            tx_buf_q      <= '0;
            tx_full_q     <= 1'b0;
            dout_q        <= 1'b0;
            rx_valid_q    <= 1'b0;
            tx_underrun_q <= 1'b0;
            frame_abort_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            sclk_sync_q   <= sclk_sync_d;
            csb_sync_q    <= csb_sync_d;
            din_sync_q    <= din_sync_d;
            bit_cnt_q     <= bit_cnt_d;
            tx_sr_q       <= tx_sr_d;
            rx_sr_q       <= rx_sr_d;
            rx_data_q     <= rx_data_d;
            tx_buf_q      <= tx_buf_d;
            tx_full_q     <= tx_full_d;
            dout_q        <= dout_d;
            rx_valid_q    <= rx_valid_d;
            tx_underrun_q <= tx_underrun_d;
            frame_abort_q <= frame_abort_d;
        end
    end

    assign dout        = dout_q;
    assign tx_ready    = ~tx_full_q;
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign busy        = (state_q == StActive);
    assign tx_underrun = tx_underrun_q;
    assign frame_abort = frame_abort_q;

endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: directed bench for spi_slave with a behavioural SPI master
// at a half-period of 4 clk cycles (clk_divider = 8).
module tb_spi_slave;

    localparam int unsigned W = 16;
    localparam int          H = 4;

    logic         clk = 1'b0;
    logic         resetb, cpol, cpha, sclk, csb, din, tx_load;
    logic [W-1:0] tx_data;
    logic         dout, tx_ready, rx_valid, busy, tx_underrun, frame_abort;
    logic [W-1:0] rx_data;

    always #5 clk = ~clk;

    spi_slave #(.DATA_WIDTH(W)) dut (
        .clk        (clk),
        .resetb     (resetb),
        .CPOL       (cpol),
        .CPHA       (cpha),
        .sclk       (sclk),
        .csb        (csb),
        .din        (din),
        .dout       (dout),
        .tx_data    (tx_data),
        .tx_load    (tx_load),
        .tx_ready   (tx_ready),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .busy       (busy),
        .tx_underrun(tx_underrun),
        .frame_abort(frame_abort)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Pulse monitor. An underrun coinciding with rx_valid belongs to the word
    // starting right after it; only those inside the frame are counted as mid.
    logic         mon_clr = 1'b0;
    int           words_in_frame = 1;
    int           rxv_cnt, urun_start, urun_mid, abort_cnt;
    logic [W-1:0] rx_hist[2];

    always @(negedge clk) begin
        if (mon_clr) begin
            rxv_cnt    = 0;
            urun_start = 0;
            urun_mid   = 0;
            abort_cnt  = 0;
            rx_hist[0] = '0;
            rx_hist[1] = '0;
        end else begin
            if (tx_underrun) begin
                if (!rx_valid) urun_start++;
                else if (rxv_cnt < words_in_frame - 1) urun_mid++;
            end
            if (rx_valid) begin
                if (rxv_cnt < 2) rx_hist[rxv_cnt] = rx_data;
                rxv_cnt++;
            end
            if (frame_abort) abort_cnt++;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic clear_mon();
        mon_clr = 1'b1;
        @(negedge clk);
        @(negedge clk);
        mon_clr = 1'b0;
    endtask

    task automatic load_tx(input logic [W-1:0] v);
        int i = 0;
        while (!tx_ready && i < 200) begin
            @(negedge clk);
            i++;
        end
        chk("tx_ready_wait", {31'd0, tx_ready}, 32'd1);
        tx_data = v;
        tx_load = 1'b1;
        @(negedge clk);
        tx_load = 1'b0;
        chk("tx_ready_drop", {31'd0, tx_ready}, 32'd0);
    endtask

    // nbits is the number of bits sent of the final word (W for a full word).
    task automatic master_frame(input logic [W-1:0] w0, input logic [W-1:0] w1,
                                input int nwords, input int nbits,
                                output logic [W-1:0] r0, output logic [W-1:0] r1);
        logic [W-1:0] mw[2];
        logic [W-1:0] mr[2];
        int nb, b;
        mw[0] = w0;
        mw[1] = w1;
        mr[0] = '0;
        mr[1] = '0;
        @(negedge clk);
        sclk = cpol;
        repeat (8) @(negedge clk);
        csb = 1'b0;
        if (!cpha) din = mw[0][W-1];
        repeat (H) @(negedge clk);
        for (int w = 0; w < nwords; w++) begin
            nb = (w == nwords - 1) ? nbits : W;
            for (int i = 0; i < nb; i++) begin
                b = W - 1 - i;
                if (!cpha) begin
                    mr[w][b] = dout;
                    sclk = ~cpol;
                    repeat (H) @(negedge clk);
                    sclk = cpol;
                    if (b > 0) din = mw[w][b-1];
                    else if (w + 1 < nwords) din = mw[w+1][W-1];
                    repeat (H) @(negedge clk);
                end else begin
                    sclk = ~cpol;
                    din = mw[w][b];
                    repeat (H) @(negedge clk);
                    mr[w][b] = dout;
                    sclk = cpol;
                    repeat (H) @(negedge clk);
                end
            end
        end
        repeat (H) @(negedge clk);
        csb = 1'b1;
        din = 1'b0;
        repeat (12) @(negedge clk);
        r0 = mr[0];
        r1 = mr[1];
    endtask

    typedef struct {
        logic         cpol;
        logic         cpha;
        logic [W-1:0] tx;
        logic [W-1:0] mosi;
        logic [W-1:0] exp_miso;
        logic [W-1:0] exp_rx;
    } vec_t;

    vec_t vecs[4];

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [W-1:0] r0, r1;
        vecs[0] = '{1'b0, 1'b0, 16'hA55A, 16'h1234, 16'hA55A, 16'h1234};
        vecs[1] = '{1'b0, 1'b1, 16'h8001, 16'hFFFE, 16'h8001, 16'hFFFE};
        vecs[2] = '{1'b1, 1'b0, 16'h8001, 16'hFFFE, 16'h8001, 16'hFFFE};
        vecs[3] = '{1'b1, 1'b1, 16'h8001, 16'hFFFE, 16'h8001, 16'hFFFE};

        resetb = 1'b0; cpol = 1'b0; cpha = 1'b0; sclk = 1'b0; csb = 1'b1; din = 1'b0;
        tx_load = 1'b0; tx_data = '0;
        repeat (3) @(negedge clk);
        resetb = 1'b1;
        @(negedge clk);
        chk("rst_dout", {31'd0, dout}, 32'd0);
        chk("rst_rx_data", {16'd0, rx_data}, 32'd0);
        chk("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
        chk("rst_tx_ready", {31'd0, tx_ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_tx_underrun", {31'd0, tx_underrun}, 32'd0);
        chk("rst_frame_abort", {31'd0, frame_abort}, 32'd0);

        // Single-word exchange in each mode.
        for (int v = 0; v < 4; v++) begin
            cpol = vecs[v].cpol;
            cpha = vecs[v].cpha;
            clear_mon();
            words_in_frame = 1;
            load_tx(vecs[v].tx);
            master_frame(vecs[v].mosi, '0, 1, W, r0, r1);
            chk($sformatf("m%0d_rx_data", v), {16'd0, rx_data}, {16'd0, vecs[v].exp_rx});
            chk($sformatf("m%0d_miso", v), {16'd0, r0}, {16'd0, vecs[v].exp_miso});
            chk($sformatf("m%0d_rx_valid_cnt", v), rxv_cnt, 1);
            chk($sformatf("m%0d_urun_start", v), urun_start, 0);
            chk($sformatf("m%0d_tx_ready_after", v), {31'd0, tx_ready}, 32'd1);
            chk($sformatf("m%0d_busy_after", v), {31'd0, busy}, 32'd0);
            chk($sformatf("m%0d_abort", v), abort_cnt, 0);
        end

        // Back-to-back words with buffer refill during the first word.
        cpol = 1'b0; cpha = 1'b0;
        clear_mon();
        words_in_frame = 2;
        load_tx(16'h1111);
        fork
            master_frame(16'h0F0F, 16'hF00F, 2, W, r0, r1);
            load_tx(16'h2222);
        join
        chk("b2b_miso0", {16'd0, r0}, 32'h1111);
        chk("b2b_miso1", {16'd0, r1}, 32'h2222);
        chk("b2b_rx_valid_cnt", rxv_cnt, 2);
        chk("b2b_rx0", {16'd0, rx_hist[0]}, 32'h0F0F);
        chk("b2b_rx1", {16'd0, rx_hist[1]}, 32'hF00F);
        chk("b2b_urun", urun_start + urun_mid, 0);

        // Underrun: frame starts with the buffer empty.
        chk("ur_tx_ready_pre", {31'd0, tx_ready}, 32'd1);
        clear_mon();
        words_in_frame = 1;
        master_frame(16'h3C3C, '0, 1, W, r0, r1);
        chk("ur_urun_start", urun_start, 1);
        chk("ur_miso", {16'd0, r0}, 32'h0000);
        chk("ur_rx_data", {16'd0, rx_data}, 32'h3C3C);
        chk("ur_rx_valid_cnt", rxv_cnt, 1);

        // Abort after 7 bits; the buffered word must survive into the next frame.
        clear_mon();
        load_tx(16'h0F0F);
        fork
            master_frame(16'hFFFF, '0, 1, 7, r0, r1);
            load_tx(16'h4242);
        join
        chk("ab_abort_cnt", abort_cnt, 1);
        chk("ab_rx_valid_cnt", rxv_cnt, 0);
        chk("ab_rx_data", {16'd0, rx_data}, 32'h3C3C);
        chk("ab_tx_ready", {31'd0, tx_ready}, 32'd0);
        clear_mon();
        master_frame(16'h1357, '0, 1, W, r0, r1);
        chk("ab_next_rx_data", {16'd0, rx_data}, 32'h1357);
        chk("ab_next_miso", {16'd0, r0}, 32'h4242);
        chk("ab_next_rx_valid_cnt", rxv_cnt, 1);
        chk("ab_next_abort", abort_cnt, 0);
        chk("ab_next_urun", urun_start, 0);

        // Bypass: tx_load lands in the same cycle the csb fall is acted on.
        chk("bp_tx_ready_pre", {31'd0, tx_ready}, 32'd1);
        clear_mon();
        fork
            master_frame(16'h2468, '0, 1, W, r0, r1);
            begin
                wait (csb == 1'b0);
                repeat (2) @(negedge clk);
                tx_data = 16'h5A5A;
                tx_load = 1'b1;
                @(negedge clk);
                tx_load = 1'b0;
            end
        join
        chk("bp_miso", {16'd0, r0}, 32'h5A5A);
        chk("bp_urun_start", urun_start, 0);
        chk("bp_rx_data", {16'd0, rx_data}, 32'h2468);
        chk("bp_tx_ready", {31'd0, tx_ready}, 32'd1);

        // Reset pulse mid-word with the tx buffer full.
        load_tx(16'h0A0A);
        fork
            master_frame(16'hFFFF, '0, 1, W, r0, r1);
            begin
                wait (csb == 1'b0);
                load_tx(16'h7777);
                repeat (40) @(negedge clk);
                chk("rs_busy_pre", {31'd0, busy}, 32'd1);
                resetb = 1'b0;
                #1;
                chk("rs_dout", {31'd0, dout}, 32'd0);
                chk("rs_rx_data", {16'd0, rx_data}, 32'd0);
                chk("rs_rx_valid", {31'd0, rx_valid}, 32'd0);
                chk("rs_tx_ready", {31'd0, tx_ready}, 32'd1);
                chk("rs_busy", {31'd0, busy}, 32'd0);
                chk("rs_tx_underrun", {31'd0, tx_underrun}, 32'd0);
                chk("rs_frame_abort", {31'd0, frame_abort}, 32'd0);
                @(negedge clk);
                resetb = 1'b1;
            end
        join

        // Clean frame after the reset.
        clear_mon();
        load_tx(16'hC3C3);
        master_frame(16'h6996, '0, 1, W, r0, r1);
        chk("post_rx_data", {16'd0, rx_data}, 32'h6996);
        chk("post_miso", {16'd0, r0}, 32'hC3C3);
        chk("post_rx_valid_cnt", rxv_cnt, 1);
        chk("post_abort", abort_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
